// File: rtl/cic_interp_stream.sv
// rtl/cic_interp_stream.sv - streaming CIC interpolator with selectable rate
// Comb chain runs at input rate, integrators at output rate; output is normalised, rounded and saturated.
module cic_interp_stream #(
    parameter int BW            = 16,
    parameter int N             = 4,
    parameter int LOG2_MAX_RATE = 7
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     enable,
    input  logic [LOG2_MAX_RATE:0]   rate,
    input  logic signed [BW-1:0]     in_tdata,
    input  logic                     in_tvalid,
    output logic                     in_tready,
    output logic signed [BW-1:0]     out_tdata,
    output logic                     out_tvalid,
    input  logic                     out_tready,
    output logic                     clip
);

    localparam int W  = BW + N + (N-1)*LOG2_MAX_RATE;
    localparam int RW = LOG2_MAX_RATE + 1;

    localparam logic [RW-1:0]        R_MAX   = {1'b1, {LOG2_MAX_RATE{1'b0}}};
    localparam logic [RW-1:0]        R_ONE   = {{LOG2_MAX_RATE{1'b0}}, 1'b1};
    localparam logic signed [W-1:0]  SAT_MAX = {{(W-BW+1){1'b0}}, {(BW-1){1'b1}}};
    localparam logic signed [W-1:0]  SAT_MIN = {{(W-BW+1){1'b1}}, {(BW-1){1'b0}}};
    localparam logic signed [BW-1:0] OUT_MAX = {1'b0, {(BW-1){1'b1}}};
    localparam logic signed [BW-1:0] OUT_MIN = {1'b1, {(BW-1){1'b0}}};

    function automatic logic [RW-1:0] clamp_rate(input logic [RW-1:0] r);
        if (r == '0)
            return R_ONE;
        else if (r > R_MAX)
            return R_MAX;
        else
            return r;
    endfunction

    function automatic int ceil_log2(input logic [RW-1:0] r);
        int cl;
        cl = 0;
        for (int k = 0; k < LOG2_MAX_RATE; k++) begin
            if ((32'd1 << k) < 32'(r))
                cl = k + 1;
        end
        return cl;
    endfunction

    logic [RW-1:0]        r_q, r_d;
    logic [RW-1:0]        phase_q, phase_d;
    logic signed [W-1:0]  d_q [N];
    logic signed [W-1:0]  d_d [N];
    logic signed [W-1:0]  c_q [N];
    logic signed [W-1:0]  c_d [N];
    logic signed [W-1:0]  i_q [N];
    logic signed [W-1:0]  i_d [N];
    logic signed [BW-1:0] out_tdata_q, out_tdata_d;
    logic                 out_tvalid_q, out_tvalid_d;
    logic                 clip_q, clip_d;

    logic [RW-1:0]        r_eff;
    int                   shift_amt;
    logic signed [W-1:0]  round_bias;
    logic signed [W-1:0]  rounded;
    logic signed [W-1:0]  shifted;
    logic                 sat_hi, sat_lo;
    logic signed [BW-1:0] norm;
    logic signed [W-1:0]  x_ext;
    logic                 ready_ok, accept, adv;

    // A latched value of 0 only occurs straight out of reset and behaves as R=1.
    assign r_eff      = clamp_rate(r_q);
    assign shift_amt  = (N-1) * ceil_log2(r_eff);
    assign round_bias = (shift_amt == 0) ? '0 : (W'(1) << (shift_amt - 1));
    assign rounded    = i_q[N-1] + round_bias;
    assign shifted    = rounded >>> shift_amt;
    assign sat_hi     = shifted > SAT_MAX;
    assign sat_lo     = shifted < SAT_MIN;
    assign norm       = sat_hi ? OUT_MAX : (sat_lo ? OUT_MIN : shifted[BW-1:0]);
    assign x_ext      = {{(W-BW){in_tdata[BW-1]}}, in_tdata};

    // reset_n gates the handshake so no input is taken while registers are held in reset.
    assign ready_ok   = reset_n && enable && (!out_tvalid_q || out_tready);
    assign in_tready  = ready_ok && (phase_q == '0);
    assign accept     = in_tvalid && in_tready;
    assign adv        = ready_ok && ((phase_q != '0) || in_tvalid);

    assign out_tdata  = out_tdata_q;
    assign out_tvalid = out_tvalid_q;
    assign clip       = clip_q;

    always_comb begin
        r_d          = r_q;
        phase_d      = phase_q;
        out_tdata_d  = out_tdata_q;
        out_tvalid_d = out_tvalid_q;
        clip_d       = 1'b0;
        for (int i = 0; i < N; i++) begin
            d_d[i] = d_q[i];
            c_d[i] = c_q[i];
            i_d[i] = i_q[i];
        end

        if (!enable) begin
            r_d          = clamp_rate(rate);
            phase_d      = '0;
            out_tdata_d  = '0;
            out_tvalid_d = 1'b0;
            for (int i = 0; i < N; i++) begin
                d_d[i] = '0;
                c_d[i] = '0;
                i_d[i] = '0;
            end
        end else begin
            if (accept) begin
                d_d[0] = x_ext;
                c_d[0] = x_ext - d_q[0];
                for (int i = 1; i < N; i++) begin
                    d_d[i] = c_q[i-1];
                    c_d[i] = c_q[i-1] - d_q[i];
                end
            end

            // Zero-stuffing: the comb output enters the integrators only on phase 0.
            if (adv) begin
                i_d[0] = i_q[0] + ((phase_q == '0) ? c_q[N-1] : '0);
                for (int i = 1; i < N; i++)
                    i_d[i] = i_q[i] + i_q[i-1];
                phase_d      = (phase_q == r_eff - R_ONE) ? '0 : phase_q + R_ONE;
                out_tdata_d  = norm;
                out_tvalid_d = 1'b1;
                clip_d       = sat_hi || sat_lo;
            end else if (out_tvalid_q && out_tready) begin
                out_tvalid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_q          <= '0;
            phase_q      <= '0;
            out_tdata_q  <= '0;
            out_tvalid_q <= 1'b0;
            clip_q       <= 1'b0;
            for (int i = 0; i < N; i++) begin
                d_q[i] <= '0;
                c_q[i] <= '0;
                i_q[i] <= '0;
            end
        end else begin
            r_q          <= r_d;
            phase_q      <= phase_d;
            out_tdata_q  <= out_tdata_d;
            out_tvalid_q <= out_tvalid_d;
            clip_q       <= clip_d;
            for (int i = 0; i < N; i++) begin
                d_q[i] <= d_d[i];
                c_q[i] <= c_d[i];
                i_q[i] <= i_d[i];
            end
        end
    end

endmodule
